// File: rtl/piso_serializer_pkg.sv
// ----------------------------------------------------------------------------
// serializer_pkg
// Shared types and constants for the parallel-in serial-out serializer.
//   ser_state_t        : FSM state encoding (PARITY is only entered when the
//                        PISO_SERIALIZER_PARITY_EN macro is defined)
//   SER_MAX_WIDTH      : widest word the serializer supports
//   calc_even_parity() : XOR-reduction of a word, zero-extended to
//                        SER_MAX_WIDTH bits (zero padding does not change it)
// ----------------------------------------------------------------------------
package serializer_pkg;

   localparam int SER_MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

   // Even parity bit: set when the word holds an odd number of ones, so that
   // word plus parity bit always carries an even count.
   function automatic logic calc_even_parity(input logic [SER_MAX_WIDTH-1:0] i_word);
      return ^i_word;
   endfunction

endpackage : serializer_pkg

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out serializer. Accepts one WIDTH-bit word through a
// valid/ready handshake while idle, then presents it one bit per enabled
// clock on o_data_out_serial, MSB or LSB first. A one-cycle o_done pulse marks
// the first idle cycle after the last bit was consumed; a new word can be
// accepted in that same cycle.
//
// Optional feature (macro PISO_SERIALIZER_PARITY_EN): an even-parity bit of
// the accepted word is appended after the last data bit (WIDTH+1 bits).
//
// Parameters
//   WIDTH      word width, 2..32
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
// Ports
//   i_clk               system clock, posedge
//   i_rst               synchronous reset, active-high, overrides everything
//   i_en                shift advance; current bit consumed when i_en && o_bit_valid
//   i_load_valid        parallel word offered
//   o_load_ready        word can be accepted (idle only)
//   i_data_in_parallel  word sampled on i_load_valid && o_load_ready
//   o_data_out_serial   current serial bit (0 while idle)
//   o_bit_valid         o_data_out_serial carries a real bit
//   o_busy              word in flight
//   o_done              one-cycle pulse after the last bit was consumed
// All outputs are registered: they are computed from the next-state values so
// they line up with the state register without a combinational path.
// ----------------------------------------------------------------------------
module piso_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH     = 24,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_load_valid,
   output logic             o_load_ready,
   input  logic [WIDTH-1:0] i_data_in_parallel,
   output logic             o_data_out_serial,
   output logic             o_bit_valid,
   output logic             o_busy,
   output logic             o_done
);

   localparam int              CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

   ser_state_t       r_state;
   ser_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [WIDTH-1:0] w_shreg_shifted;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             w_done_nxt;
   logic             w_bit_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
   logic             r_parity;
   logic             w_parity_nxt;
`endif

   // Shift toward the output end with zero fill.
   always_comb begin
      w_shreg_shifted = '0;
      if (MSB_FIRST) begin
         w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
         w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      end
   end

   // Next-state, next-datapath and done-pulse logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_count_nxt  = r_count;
      w_done_nxt   = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      w_parity_nxt = r_parity;
`endif
      case (r_state)
         IDLE: begin
            if (i_load_valid) begin
               w_state_nxt  = SHIFT;
               w_shreg_nxt  = i_data_in_parallel;
               w_count_nxt  = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
               w_parity_nxt = calc_even_parity(SER_MAX_WIDTH'(i_data_in_parallel));
`endif
            end else begin
               w_state_nxt  = IDLE;
            end
         end
         SHIFT: begin
            if (i_en) begin
               w_shreg_nxt = w_shreg_shifted;
               w_count_nxt = r_count + CW'(1);
               if (r_count == LAST_IDX) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
`endif
               end else begin
                  w_state_nxt = SHIFT;
               end
            end else begin
               // Stall: hold everything for as long as i_en stays low.
               w_state_nxt = SHIFT;
            end
         end
`ifdef PISO_SERIALIZER_PARITY_EN
         PARITY: begin
            if (i_en) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = PARITY;
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
            w_shreg_nxt = '0;
            w_count_nxt = '0;
         end
      endcase
   end

   // Serial bit that will be on the pin after this edge.
   always_comb begin
      w_bit_nxt = 1'b0;
      case (w_state_nxt)
         SHIFT: begin
            if (MSB_FIRST) begin
               w_bit_nxt = w_shreg_nxt[WIDTH-1];
            end else begin
               w_bit_nxt = w_shreg_nxt[0];
            end
         end
`ifdef PISO_SERIALIZER_PARITY_EN
         PARITY: begin
            w_bit_nxt = w_parity_nxt;
         end
`endif
         default: begin
            w_bit_nxt = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state           <= IDLE;
         r_shreg           <= '0;
         r_count           <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
         r_parity          <= 1'b0;
`endif
         o_load_ready      <= 1'b1;
         o_data_out_serial <= 1'b0;
         o_bit_valid       <= 1'b0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
      end else begin
         r_state           <= w_state_nxt;
         r_shreg           <= w_shreg_nxt;
         r_count           <= w_count_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
         r_parity          <= w_parity_nxt;
`endif
         o_load_ready      <= (w_state_nxt == IDLE);
         o_data_out_serial <= w_bit_nxt;
         o_bit_valid       <= (w_state_nxt != IDLE);
         o_busy            <= (w_state_nxt != IDLE);
         o_done            <= w_done_nxt;
      end
   end

endmodule : piso_serializer
